proc_control_unit: RTL and testbench

// - Instruction-sequencing FSM of the processor; sits directly upstream of the bus multiplexer and drives its one-hot source selector.
// - Decodes the 9-bit instruction word III_XXX_YYY latched in IR.
// - Sequences register, A, G and IR loads over 1-3 execute steps per instruction; pulses Done on completion.
//

---
 rtl/proc_control_unit.sv | 156 +++++++++++++++
 tb/tb_proc_control_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/proc_control_unit.sv
// proc_control_unit: instruction-sequencing FSM for the simple processor.
// Decodes IR = III_XXX_YYY and drives the bus-mux one-hot selector plus the
// register / A / G / IR load strobes over 1-3 execute steps per instruction.
// Optional feature macro: CU_INSTR_COUNT_EN adds the instr_count output,
// a wrapping counter of retired instructions (cycles with Done=1).
//
// state | meaning
// T0    | fetch: IRin follows Run, wait for Run
// T1    | first execute step (mv/mvi/mvnz/reserved finish here)
// T2    | ALU ops: second operand onto bus, G captures result
// T3    | ALU ops: G written back to Rx

module proc_control_unit #(
    parameter int IR_W  = 9
`ifdef CU_INSTR_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [IR_W-1:0]   IR,
    input  logic              Zero,
    output logic [9:0]        muxSeletor,
    output logic              DINout,
    output logic              Gout,
    output logic [7:0]        Rout,
    output logic [7:0]        Rin,
    output logic              IRin,
    output logic              Ain,
    output logic              Gin,
    output logic [1:0]        AluOp,
    output logic              Done
`ifdef CU_INSTR_COUNT_EN
    ,
    output logic [CNT_W-1:0]  instr_count
`endif
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVNZ = 3'b101;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic [2:0] w_op;
    logic [7:0] w_x_oh;
    logic [7:0] w_y_oh;

    assign w_op   = IR[8:6];
    assign w_x_oh = 8'd1 << IR[5:3];
    assign w_y_oh = 8'd1 << IR[2:0];

    // Next-state and output decode; everything is forced to 0 while in reset
    always_comb begin
        w_next     = r_state;
        muxSeletor = 10'd0;
        Rin        = 8'd0;
        IRin       = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        AluOp      = 2'b00;
        Done       = 1'b0;
        case (r_state)
            T0: begin
                IRin = Run;
                if (Run) w_next = T1;
            end
            T1: begin
                w_next = T0;
                case (w_op)
                    OP_MV: begin
                        muxSeletor = {w_y_oh, 2'b00};
                        Rin        = w_x_oh;
                        Done       = 1'b1;
                    end
                    OP_MVI: begin
                        muxSeletor = 10'b00_0000_0001;
                        Rin        = w_x_oh;
                        Done       = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        muxSeletor = {w_x_oh, 2'b00};
                        Ain        = 1'b1;
                        w_next     = T2;
                    end
                    OP_MVNZ: begin
                        if (!Zero) begin
                            muxSeletor = {w_y_oh, 2'b00};
                            Rin        = w_x_oh;
                        end
                        Done = 1'b1;
                    end
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                muxSeletor = {w_y_oh, 2'b00};
                Gin        = 1'b1;
                case (w_op)
                    OP_SUB:  AluOp = 2'b01;
                    OP_AND:  AluOp = 2'b10;
                    default: AluOp = 2'b00;
                endcase
                w_next = T3;
            end
            default: begin
                muxSeletor = 10'b00_0000_0010;
                Rin        = w_x_oh;
                Done       = 1'b1;
                w_next     = T0;
            end
        endcase
        if (!Resetn) begin
            muxSeletor = 10'd0;
            Rin        = 8'd0;
            IRin       = 1'b0;
            Ain        = 1'b0;
            Gin        = 1'b0;
            AluOp      = 2'b00;
            Done       = 1'b0;
        end
    end

    assign DINout = muxSeletor[0];
    assign Gout   = muxSeletor[1];
    assign Rout   = muxSeletor[9:2];

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) r_state <= T0;
        else         r_state <= w_next;
    end

`ifdef CU_INSTR_COUNT_EN
    logic [CNT_W-1:0] r_instr_count;

    // Retired-instruction counter, wraps naturally at all-ones
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)   r_instr_count <= '0;
        else if (Done) r_instr_count <= r_instr_count + 1'b1;
    end

    assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed bench for proc_control_unit. Inputs change on the falling edge,
// outputs are checked 1 time unit later.
module tb_proc_control_unit;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Run;
    logic [8:0]  IR;
    logic        Zero;
    logic [9:0]  muxSeletor;
    logic        DINout;
    logic        Gout;
    logic [7:0]  Rout;
    logic [7:0]  Rin;
    logic        IRin;
    logic        Ain;
    logic        Gin;
    logic [1:0]  AluOp;
    logic        Done;
`ifdef CU_INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    proc_control_unit dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Run        (Run),
        .IR         (IR),
        .Zero       (Zero),
        .muxSeletor (muxSeletor),
        .DINout     (DINout),
        .Gout       (Gout),
        .Rout       (Rout),
        .Rin        (Rin),
        .IRin       (IRin),
        .Ain        (Ain),
        .Gin        (Gin),
        .AluOp      (AluOp),
        .Done       (Done)
`ifdef CU_INSTR_COUNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    task automatic expect_o(input string tag, input logic [9:0] mux, input logic [7:0] rin,
                            input logic irin, input logic ain, input logic gin,
                            input logic [1:0] alu, input logic done);
        logic [33:0] obs;
        logic [33:0] exp;
        #1;
        obs = {muxSeletor, Rout, Gout, DINout, Rin, IRin, Ain, Gin, AluOp, Done};
        exp = {mux, mux[9:2], mux[1], mux[0], rin, irin, ain, gin, alu, done};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu_seq(input string name, input logic [1:0] alu);
        @(negedge Clock);
        expect_o({name, "_t1"}, 10'h008, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        @(negedge Clock);
        expect_o({name, "_t2"}, 10'h010, 8'h00, 1'b0, 1'b0, 1'b1, alu, 1'b0);
        @(negedge Clock);
        expect_o({name, "_t3"}, 10'h002, 8'h02, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    endtask

    initial begin
        Resetn = 1'b0;
        Run    = 1'b1;
        IR     = 9'b001_011_000;
        Zero   = 1'b0;
        expect_o("reset_hold", 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        @(negedge Clock); Resetn = 1'b1;
        expect_o("mvi_t0", 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge Clock);
        expect_o("mvi_t1", 10'h001, 8'h08, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

        @(negedge Clock); IR = 9'b010_001_010;
        expect_o("add_t0", 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        alu_seq("add", 2'b00);
        @(negedge Clock); IR = 9'b011_001_010;
        expect_o("sub_t0", 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        alu_seq("sub", 2'b01);
        @(negedge Clock); IR = 9'b100_001_010;
        expect_o("and_t0", 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        alu_seq("and", 2'b10);

        @(negedge Clock); IR = 9'b101_000_111; Zero = 1'b0;
        expect_o("mvnz_nz_t0", 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge Clock);
        expect_o("mvnz_nz_t1", 10'h200, 8'h01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        @(negedge Clock); Zero = 1'b1;
        expect_o("mvnz_z_t0", 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge Clock);
        expect_o("mvnz_z_t1", 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

        @(negedge Clock); IR = 9'b110_001_001; Zero = 1'b0;
        expect_o("rsv110_t0", 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge Clock);
        expect_o("rsv110_t1", 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        @(negedge Clock); IR = 9'b111_010_011;
        expect_o("rsv111_t0", 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge Clock);
        expect_o("rsv111_t1", 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

        @(negedge Clock); Run = 1'b0;
        expect_o("idle_t0", 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge Clock);
        expect_o("idle_stay", 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // add R2,R2 with Run toggling mid-instruction, aborted by reset in T2
        @(negedge Clock); Run = 1'b1; IR = 9'b010_010_010;
        expect_o("add22_t0", 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge Clock); Run = 1'b0;
        expect_o("add22_t1", 10'h010, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        @(negedge Clock); Run = 1'b1;
        expect_o("add22_t2", 10'h010, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        Resetn = 1'b0;
        expect_o("rst_mid", 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge Clock); Resetn = 1'b1; Run = 1'b0;
        expect_o("rst_release", 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge Clock);
        expect_o("rst_no_resume", 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
`ifdef CU_INSTR_COUNT_EN
        total++;
        assert (instr_count === 16'd0) else begin
            bad++;
            $error("FAIL cnt_after_reset observed=%0d expected=0", instr_count);
        end
`endif

        // three back-to-back mv R2,R5 with Run held high
        @(negedge Clock); Run = 1'b1; IR = 9'b000_010_101;
        expect_o("b2b_t0_first", 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            expect_o("b2b_t1", 10'h080, 8'h04, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
            @(negedge Clock);
            if (i == 2) Run = 1'b0;
            expect_o("b2b_t0", 10'h000, 8'h00, (i < 2), 1'b0, 1'b0, 2'b00, 1'b0);
        end
`ifdef CU_INSTR_COUNT_EN
        total++;
        assert (instr_count === 16'd3) else begin
            bad++;
            $error("FAIL cnt_b2b observed=%0d expected=3", instr_count);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
